// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end to a single 32-bit ALU
// Ports: i_clk/i_rst (sync, active-high); i_req_valid/o_req_ready per-requester handshake;
//        i_srcA_n/i_srcB_n/i_alu_control_n requester operands and opcode;
//        o_rsp_valid/i_rsp_ready response handshake; o_rsp_id/o_rsp_result/o_rsp_zero/o_rsp_illegal response payload.
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [31:0] i_srcA_0,
  input  logic [31:0] i_srcB_0,
  input  logic [2:0]  i_alu_control_0,
  input  logic [31:0] i_srcA_1,
  input  logic [31:0] i_srcB_1,
  input  logic [2:0]  i_alu_control_1,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_zero,
  output logic        o_rsp_illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      r_state;
  logic        r_ptr;
  logic        r_id;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_rsp_id;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_illegal;
  logic [1:0]  w_grant;
  logic        w_illegal;
  logic [31:0] w_result;
  always_comb begin
    w_grant = (i_req_valid == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : i_req_valid;
    o_req_ready = (r_state == IDLE && !i_rst) ? w_grant : 2'b00;
    w_illegal = (r_op == 3'b100) || (r_op[2:1] == 2'b11);
    w_result = (r_op == 3'b000) ? r_a + r_b :
               (r_op == 3'b001) ? r_a - r_b :
               (r_op == 3'b010) ? r_a & r_b :
               (r_op == 3'b011) ? r_a | r_b :
               (r_op == 3'b101) ? {31'd0, r_a < r_b} : 32'd0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_rsp_id  <= 1'b0;
      r_result  <= 32'd0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (|o_req_ready) begin
          // o_req_ready is already qualified by i_req_valid, so any set bit is a handshake
          r_id    <= o_req_ready[1];
          r_a     <= o_req_ready[1] ? i_srcA_1 : i_srcA_0;
          r_b     <= o_req_ready[1] ? i_srcB_1 : i_srcB_0;
          r_op    <= o_req_ready[1] ? i_alu_control_1 : i_alu_control_0;
          r_ptr   <= ~o_req_ready[1];
          r_state <= EXEC;
        end
        EXEC: begin
          r_rsp_id  <= r_id;
          r_result  <= w_result;
          r_zero    <= (w_result == 32'd0);
          r_illegal <= w_illegal;
          r_state   <= RESP;
        end
        RESP: if (i_rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_result  = r_result;
  assign o_rsp_zero    = r_zero;
  assign o_rsp_illegal = r_illegal;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_req_valid = 2'b00;
  logic [1:0]  o_req_ready;
  logic [31:0] i_srcA_0 = 32'd0;
  logic [31:0] i_srcB_0 = 32'd0;
  logic [2:0]  i_alu_control_0 = 3'd0;
  logic [31:0] i_srcA_1 = 32'd0;
  logic [31:0] i_srcB_1 = 32'd0;
  logic [2:0]  i_alu_control_1 = 3'd0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic        o_rsp_id;
  logic [31:0] o_rsp_result;
  logic        o_rsp_zero;
  logic        o_rsp_illegal;
  int n_chk = 0;
  int n_fail = 0;
  alu_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_srcA_0(i_srcA_0), .i_srcB_0(i_srcB_0), .i_alu_control_0(i_alu_control_0),
    .i_srcA_1(i_srcA_1), .i_srcB_1(i_srcB_1), .i_alu_control_1(i_alu_control_1),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero), .o_rsp_illegal(o_rsp_illegal)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    i_srcA_0 = a;
    i_srcB_0 = b;
    i_alu_control_0 = op;
  endtask
  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    i_srcA_1 = a;
    i_srcB_1 = b;
    i_alu_control_1 = op;
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    i_req_valid = 2'b00;
    i_rsp_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] valid, input logic [1:0] exp_rdy,
                     input logic exp_id, input logic [31:0] exp_res, input logic exp_z, input logic exp_ill);
    i_req_valid = valid;
    #1;
    chk({tag, "_ready"}, 32'(o_req_ready), 32'(exp_rdy));
    tick();
    i_req_valid = 2'b00;
    set0($urandom, $urandom, 3'($urandom));
    set1($urandom, $urandom, 3'($urandom));
    chk({tag, "_exec_valid"}, 32'(o_rsp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(o_rsp_id), 32'(exp_id));
    chk({tag, "_result"}, o_rsp_result, exp_res);
    chk({tag, "_zero"}, 32'(o_rsp_zero), 32'(exp_z));
    chk({tag, "_illegal"}, 32'(o_rsp_illegal), 32'(exp_ill));
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk({tag, "_done"}, 32'(o_rsp_valid), 32'd0);
  endtask
  initial begin
    i_req_valid = 2'b11;
    tick();
    #1;
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    tick();
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_id", 32'(o_rsp_id), 32'd0);
    chk("rst_result", o_rsp_result, 32'd0);
    chk("rst_zero", 32'(o_rsp_zero), 32'd0);
    chk("rst_illegal", 32'(o_rsp_illegal), 32'd0);
    do_reset();
    set0(32'd5, 32'd7, 3'b000);
    run("single", 2'b01, 2'b01, 1'b0, 32'd12, 1'b0, 1'b0);
    do_reset();
    set0(32'd10, 32'd3, 3'b001);
    set1(32'hF0, 32'h3C, 3'b010);
    i_req_valid = 2'b11;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", 32'(o_req_ready), (i % 2) ? 32'd2 : 32'd1);
      tick();
      chk("rr_exec_valid", 32'(o_rsp_valid), 32'd0);
      tick();
      chk("rr_valid", 32'(o_rsp_valid), 32'd1);
      chk("rr_id", 32'(o_rsp_id), 32'(i % 2));
      chk("rr_result", o_rsp_result, (i % 2) ? 32'h30 : 32'd7);
      tick();
    end
    i_req_valid = 2'b00;
    i_rsp_ready = 1'b0;
    set1(32'hF0, 32'h0F, 3'b011);
    i_req_valid = 2'b10;
    #1;
    chk("bp_ready", 32'(o_req_ready), 32'd2);
    tick();
    i_req_valid = 2'b11;
    set1(32'h1, 32'h1, 3'b000);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_result", o_rsp_result, 32'hFF);
      chk("bp_id", 32'(o_rsp_id), 32'd1);
      chk("bp_noready", 32'(o_req_ready), 32'd0);
      tick();
    end
    i_rsp_ready = 1'b1;
    #1;
    chk("bp_hold_ready", 32'(o_req_ready), 32'd0);
    tick();
    i_rsp_ready = 1'b0;
    i_req_valid = 2'b00;
    chk("bp_done", 32'(o_rsp_valid), 32'd0);
    set0(32'hFFFFFFFF, 32'd1, 3'b000);
    run("add_wrap", 2'b01, 2'b01, 1'b0, 32'd0, 1'b1, 1'b0);
    set0(32'd0, 32'd1, 3'b001);
    run("sub_wrap", 2'b01, 2'b01, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    set0(32'd1, 32'hFFFFFFFF, 3'b101);
    run("sltu", 2'b01, 2'b01, 1'b0, 32'd1, 1'b0, 1'b0);
    set0(32'hFFFFFFFF, 32'd1, 3'b101);
    run("sltu_n", 2'b01, 2'b01, 1'b0, 32'd0, 1'b1, 1'b0);
    set1(32'h1234, 32'h5678, 3'b110);
    run("illegal", 2'b10, 2'b10, 1'b1, 32'd0, 1'b1, 1'b1);
    set0(32'd3, 32'd4, 3'b000);
    i_req_valid = 2'b01;
    tick();
    i_req_valid = 2'b00;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_valid", 32'(o_rsp_valid), 32'd0);
      tick();
    end
    i_rsp_ready = 1'b0;
    i_req_valid = 2'b11;
    #1;
    chk("abort_ptr", 32'(o_req_ready), 32'd1);
    i_req_valid = 2'b00;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, two requesters, 3-bit ALU op encoding.
REQ-002 i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_valid  input  2  bit n = requester n presents an operation.
REQ-005 o_req_ready  output  2  bit n = arbiter accepts requester n this cycle.
REQ-006 i_srcA_0, i_srcB_0  input  32 each  requester 0 operands.
REQ-007 i_alu_control_0  input  3  requester 0 opcode.
REQ-008 i_srcA_1, i_srcB_1  input  32 each  requester 1 operands.
REQ-009 i_alu_control_1  input  3  requester 1 opcode.
REQ-010 o_rsp_valid  output  1  response held for consumer.
REQ-011 i_rsp_ready  input  1  consumer takes response this cycle.
REQ-012 o_rsp_id  output  1  requester index owning the response.
REQ-013 o_rsp_result  output  32  ALU result.
REQ-014 o_rsp_zero  output  1  1 when o_rsp_result == 0.
REQ-015 o_rsp_illegal  output  1  1 when captured opcode is not a defined operation.

Function
REQ-016 Request handshake on requester n completes when i_req_valid[n] & o_req_ready[n]; response handshake completes when o_rsp_valid & i_rsp_ready.
REQ-017 FSM states IDLE, EXEC, RESP; IDLE->EXEC on request handshake, EXEC->RESP unconditionally after one cycle, RESP->IDLE on response handshake, otherwise RESP holds.
REQ-018 o_req_ready is nonzero only in IDLE, is one-hot or zero, and never depends on i_rsp_ready.
REQ-019 In IDLE with exactly one valid requester, that requester gets ready; with both valid, the requester selected by the round-robin pointer gets ready.
REQ-020 Round-robin pointer flips to the non-granted requester after every request handshake; it is unchanged when no handshake occurs.
REQ-021 Operands, opcode and requester id are captured only on request handshake; inputs in other cycles are ignored.
REQ-022 A requester dropping i_req_valid before handshake causes no capture and no pointer change.
REQ-023 EXEC computes from captured values: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 101 (A<B unsigned) ? 1 : 0; arithmetic modulo 2^32, carry/borrow discarded.
REQ-024 Opcodes 100, 110, 111 produce result 0, zero 1, illegal 1; defined opcodes produce illegal 0.
REQ-025 Result, zero, illegal and id are registered at end of EXEC and held stable throughout RESP.
REQ-026 Latency: request handshake in cycle T gives o_rsp_valid=1 in cycle T+2; minimum issue interval 3 cycles (next o_req_ready no earlier than cycle after response handshake).
REQ-027 Only one operation is in flight; no request is accepted in EXEC or RESP.

Reset
REQ-028 When i_rst is high at a clock edge: state IDLE, pointer selects requester 0, o_rsp_valid 0, o_rsp_id 0, o_rsp_result 0, o_rsp_zero 0, o_rsp_illegal 0.
REQ-029 Reset during EXEC or RESP abandons the operation; no response for it is ever produced.
REQ-030 o_req_ready is 0 in any cycle where i_rst is high.

Verification
REQ-031 Single op: req0 A=5, B=7, op 000 accepted cycle T -> cycle T+2 o_rsp_valid=1, id 0, result 12, zero 0, illegal 0.
REQ-032 Contention: both valid continuously after reset, consumer always ready -> grants 0,1,0,1; each response carries matching id and result.
REQ-033 Backpressure: i_rsp_ready low 5 cycles in RESP -> outputs stable, o_req_ready stays 0, response completes on first ready cycle.
REQ-034 Boundaries: A=0xFFFFFFFF, B=1, op 000 -> result 0, zero 1; A=0, B=1, op 001 -> 0xFFFFFFFF; A=1, B=0xFFFFFFFF, op 101 -> 1.
REQ-035 Illegal opcode 110 on req1 -> result 0, zero 1, illegal 1, id 1.
REQ-036 Reset asserted in EXEC -> no o_rsp_valid afterwards; next request with both valid is granted to requester 0.
